// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged FIFO family.
package fifo_pkg;

   localparam int AF_OFFSET  = 2;
   localparam int AE_DEFAULT = 2;

   // Bits needed to hold values 0..depth inclusive.
   function automatic int count_width(input int depth);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) <= depth) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/fifo_flagged_ctrl.sv
// Pointer, occupancy and error-flag control for fifo_flagged.
module fifo_flagged_ctrl
   import fifo_pkg::*;
#(
   parameter int W        = 4,
   parameter int AF_LEVEL = 2**W - AF_OFFSET,
   parameter int AE_LEVEL = AE_DEFAULT
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr,
   input  logic                              rd,
   input  logic                              clr_err,
   output logic                              we,
   output logic [W-1:0]                      w_ptr,
   output logic [W-1:0]                      r_ptr,
   output logic [count_width(2**W)-1:0]      count,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int CW = count_width(2**W);
   localparam logic [CW-1:0] DEPTH_C = CW'(2**W);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [W-1:0]  w_ptr_reg, w_ptr_next;
   logic [W-1:0]  r_ptr_reg, r_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          overflow_reg, overflow_next;
   logic          underflow_reg, underflow_next;
   logic          do_wr, do_rd;

   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);

   // A full FIFO still accepts a write when the same cycle pops the head.
   assign do_wr = wr & (~full | rd);
   assign do_rd = rd & ~empty;
   assign we    = do_wr;

   always_comb begin
      w_ptr_next     = w_ptr_reg;
      r_ptr_next     = r_ptr_reg;
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (do_wr) w_ptr_next = w_ptr_reg + W'(1);
      if (do_rd) r_ptr_next = r_ptr_reg + W'(1);
      case ({do_wr, do_rd})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
      // A fresh error in the clearing cycle takes priority over clr_err.
      if (wr & full & ~rd)        overflow_next = 1'b1;
      else if (clr_err)           overflow_next = 1'b0;
      if (rd & empty & ~wr)       underflow_next = 1'b1;
      else if (clr_err)           underflow_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr_reg     <= '0;
         r_ptr_reg     <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         w_ptr_reg     <= w_ptr_next;
         r_ptr_reg     <= r_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign w_ptr     = w_ptr_reg;
   assign r_ptr     = r_ptr_reg;
   assign count     = count_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: rtl/fifo_flagged.sv
// First-word-fall-through synchronous FIFO with occupancy and sticky error flags.
module fifo_flagged
   import fifo_pkg::*;
#(
   parameter int B        = 8,
   parameter int W        = 4,
   parameter int AF_LEVEL = 2**W - AF_OFFSET,
   parameter int AE_LEVEL = AE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr,
   input  logic [B-1:0]                  w_data,
   input  logic                          rd,
   input  logic                          clr_err,
   output logic [B-1:0]                  r_data,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [count_width(2**W)-1:0]  count,
   output logic                          overflow,
   output logic                          underflow
);

   logic [B-1:0] mem [2**W];
   logic [W-1:0] w_ptr, r_ptr;
   logic         we;

   fifo_flagged_ctrl #(
      .W        (W),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .clr_err      (clr_err),
      .we           (we),
      .w_ptr        (w_ptr),
      .r_ptr        (r_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Storage is left uninitialised on reset; the pointers make old words unreachable.
   always_ff @(posedge clk) begin
      if (we) mem[w_ptr] <= w_data;
   end

   assign r_data = mem[r_ptr];

endmodule

// File: tb/tb_fifo_flagged.sv
// Scoreboard testbench for fifo_flagged (B=8, W=2, AF_LEVEL=3, AE_LEVEL=1).
module tb_fifo_flagged;

   logic       clk = 1'b0;
   logic       reset, wr, rd, clr_err;
   logic [7:0] w_data, r_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q[$];
   logic       m_ov = 1'b0, m_uf = 1'b0;

   fifo_flagged #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .clr_err      (clr_err),
      .r_data       (r_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = q.size();
      check_val({tag, ".count"}, 32'(count), 32'(n));
      check_val({tag, ".empty"}, 32'(empty), 32'(n == 0));
      check_val({tag, ".full"}, 32'(full), 32'(n == 4));
      check_val({tag, ".afull"}, 32'(almost_full), 32'(n >= 3));
      check_val({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
      check_val({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
      check_val({tag, ".unf"}, 32'(underflow), 32'(m_uf));
      if (n > 0) check_val({tag, ".head"}, 32'(r_data), 32'(q[0]));
   endtask

   task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
      int n;
      wr = w; w_data = d; rd = r; clr_err = c;
      n = q.size();
      if (r && n > 0) begin
         check_val({tag, ".pop"}, 32'(r_data), 32'(q[0]));
         void'(q.pop_front());
      end
      if (w && (n < 4 || r)) q.push_back(d);
      m_ov = (w && n == 4 && !r) ? 1'b1 : (c ? 1'b0 : m_ov);
      m_uf = (r && n == 0 && !w) ? 1'b1 : (c ? 1'b0 : m_uf);
      @(posedge clk); #1;
      wr = 0; rd = 0; clr_err = 0;
      $display("txn %s wr=%0b d=%02h rd=%0b clr=%0b -> count=%0d r_data=%02h",
               tag, w, d, r, c, count, r_data);
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1; wr = 1; w_data = 8'hEE; rd = 1; clr_err = 0;
      @(posedge clk); #1;
      reset = 0; wr = 0; rd = 0;
      q.delete(); m_ov = 0; m_uf = 0;
      $display("txn %s reset -> count=%0d empty=%0b", tag, count, empty);
      check_state(tag);
   endtask

   initial begin
      reset = 1; wr = 0; rd = 0; clr_err = 0; w_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      do_reset("rst");
      cycle("idle", 0, 8'h00, 0, 0);
      // Fill to full
      cycle("w11", 1, 8'h11, 0, 0);
      cycle("w22", 1, 8'h22, 0, 0);
      cycle("w33", 1, 8'h33, 0, 0);
      cycle("w44", 1, 8'h44, 0, 0);
      cycle("wovf", 1, 8'h55, 0, 0);
      for (int i = 0; i < 4; i++) cycle("drain", 0, 8'h00, 1, 0);
      cycle("runf", 0, 8'h00, 1, 0);
      cycle("clr", 0, 8'h00, 0, 1);
      // Error in the clearing cycle wins
      cycle("runf2", 0, 8'h00, 1, 1);
      cycle("clr2", 0, 8'h00, 0, 1);
      // Simultaneous rd&wr at count=2, full and empty
      cycle("wa1", 1, 8'hA1, 0, 0);
      cycle("wa2", 1, 8'hA2, 0, 0);
      cycle("rw2", 1, 8'hA3, 1, 0);
      cycle("wa4", 1, 8'hA4, 0, 0);
      cycle("wa5", 1, 8'hA5, 0, 0);
      cycle("rwfull", 1, 8'hA6, 1, 0);
      for (int i = 0; i < 4; i++) cycle("drain2", 0, 8'h00, 1, 0);
      cycle("rwempty", 1, 8'hB7, 1, 0);
      // Pointer wrap with count held at 1
      for (int i = 0; i < 10; i++) cycle("wrap", 1, 8'(8'hC0 + i), 1, 0);
      // Mid-stream reset at count=3
      cycle("wd1", 1, 8'hD1, 0, 0);
      cycle("wd2", 1, 8'hD2, 0, 0);
      do_reset("midrst");
      cycle("post", 1, 8'hE1, 0, 0);
      cycle("postrd", 0, 8'h00, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
